instr_encoder: RTL

- Pipelined RISC-V RV32I instruction encoder: the inverse of the instruction decoder.
- Accepts decoded fields (opcode, funct3, funct7, rd, rs1, rs2, imm, instr_type) and emits the packed 32-bit instruction word.
- Sits in the program-loader / self-test path. Feeds instruction memory with sequential word addresses under a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/instr_pack.sv | 57 +++++
 rtl/instr_encoder.sv | 95 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the field bundle carried by the encoder.
// Holds instr_type codes, opcodes, the canonical NOP and an immediate range helper.
package riscv_pkg;

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  itype;
    } enc_fields_t;

    // Signed inclusive range test on a sign-extended immediate.
    function automatic logic imm_fits(input logic [31:0] imm,
                                      input int lo,
                                      input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields + instr_type -> 32-bit word and error flag.
// Ports: fields (bundle in), word (packed instruction), err (field error).
// Range checking is compiled in with INSTR_ENCODER_RANGE_CHECK_EN.
module instr_pack
    import riscv_pkg::*;
(
    input  enc_fields_t fields,
    output logic [31:0] word,
    output logic        err
);

    logic [31:0] imm;
    logic [31:0] raw;
    logic        bad;

    assign imm = fields.imm;

    always_comb begin
        raw = '0;
        case (fields.itype)
            TYPE_I: raw = {imm[11:0], fields.rs1, fields.funct3,
                           fields.rd, fields.opcode};
            TYPE_S: raw = {imm[11:5], fields.rs2, fields.rs1,
                           fields.funct3, imm[4:0], fields.opcode};
            TYPE_B: raw = {imm[12], imm[10:5], fields.rs2, fields.rs1,
                           fields.funct3, imm[4:1], imm[11], fields.opcode};
            TYPE_U: raw = {imm[31:12], fields.rd, fields.opcode};
            TYPE_J: raw = {imm[20], imm[10:1], imm[11], imm[19:12],
                           fields.rd, fields.opcode};
            // R-type and the unused codes 6/7 share the register layout
            default: raw = {fields.funct7, fields.rs2, fields.rs1,
                            fields.funct3, fields.rd, fields.opcode};
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    always_comb begin
        bad = (fields.opcode[1:0] != 2'b11);
        case (fields.itype)
            TYPE_R: ;
            TYPE_I,
            TYPE_S: if (!imm_fits(imm, -2048, 2047)) bad = 1'b1;
            TYPE_B: if (!imm_fits(imm, -4096, 4094) || imm[0]) bad = 1'b1;
            TYPE_U: if (imm[11:0] != 12'h000) bad = 1'b1;
            TYPE_J: if (!imm_fits(imm, -(1 << 20), (1 << 20) - 2) || imm[0])
                        bad = 1'b1;
            default: bad = 1'b1;
        endcase
    end
`else
    assign bad = 1'b0;
`endif

    assign word = bad ? RV_NOP : raw;
    assign err  = bad;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder feeding instruction memory sequentially.
// Ports: clk/rst, in_* field bundle with valid/ready, addr_clr, out_* word with
// valid/ready, out_addr, out_err, err_count. Macro INSTR_ENCODER_RANGE_CHECK_EN
// enables field checking; without it out_err and err_count stay zero.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_type,
    input  logic        addr_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);

    enc_fields_t in_f;
    enc_fields_t s1_f;
    logic        s1_valid;
    logic        s2_adv;
    logic        out_hs;
    logic [31:0] pk_word;
    logic        pk_err;

    assign in_f = '{opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                    rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    imm: in_imm, itype: in_type};

    assign s2_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;
    assign out_hs   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_f <= in_f;
        end
    end

    instr_pack u_pack (
        .fields (s1_f),
        .word   (pk_word),
        .err    (pk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            out_word  <= pk_word;
            out_err   <= pk_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // addr_clr outranks the step; the word being handed over keeps its address
    always_ff @(posedge clk) begin
        if (rst || addr_clr) out_addr <= BASE_ADDR;
        else if (out_hs)     out_addr <= out_addr + ADDR_STEP;
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (out_hs && out_err && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule
